// File: rtl/led_fade_driver.sv
// led_fade_driver: per-LED PWM drive with global brightness, linear fade and blink
module led_fade_driver #(
    parameter int N_LEDS      = 14,
    parameter int DUTY_W      = 4,
    parameter int PWM_DIV     = 4,
    parameter int STEP_FRAMES = 2,
    parameter int BLINK_STEPS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_pattern,
    input  logic [DUTY_W-1:0] brightness,
    input  logic              fade_en,
    input  logic              blink_en,
    output logic [N_LEDS-1:0] led_o,
    output logic              busy
);
    localparam int PS_W = $clog2(PWM_DIV + 1);
    localparam int FR_W = $clog2(STEP_FRAMES + 1);
    localparam int BL_W = $clog2(BLINK_STEPS + 1);
    localparam logic [DUTY_W-1:0] MAX = '1;

    logic [N_LEDS-1:0] r_pattern;
    logic [PS_W-1:0]   r_ps;
    logic [DUTY_W-1:0] r_pwm;
    logic [FR_W-1:0]   r_frame;
    logic [BL_W-1:0]   r_blink;
    logic              r_blink_phase;
    logic [DUTY_W-1:0] r_level [N_LEDS];

    logic              w_tick;
    logic              w_frame_end;
    logic              w_step;
    logic              w_blink_wrap;
    logic              w_hide;
    logic [DUTY_W-1:0] w_target [N_LEDS];
    logic [DUTY_W-1:0] w_next [N_LEDS];
    logic [N_LEDS-1:0] w_diff;
    logic [N_LEDS-1:0] w_on;

    assign w_tick       = r_ps == PS_W'(PWM_DIV - 1);
    assign w_frame_end  = w_tick & (r_pwm == MAX);
    assign w_step       = w_frame_end & (r_frame == FR_W'(STEP_FRAMES - 1));
    assign w_blink_wrap = w_step & (r_blink == BL_W'(BLINK_STEPS - 1));
    assign w_hide       = blink_en & r_blink_phase;

    // Per-LED target, next level (snap or one fade step toward target), mismatch and PWM compare
    always_comb begin
        for (int i = 0; i < N_LEDS; i++) begin
            w_target[i] = (r_pattern[i] & ~w_hide) ? brightness : '0;
            w_next[i]   = !fade_en ? w_target[i] :
                          !w_step ? r_level[i] :
                          (r_level[i] < w_target[i]) ? r_level[i] + 1'b1 :
                          (r_level[i] > w_target[i]) ? r_level[i] - 1'b1 : r_level[i];
            w_diff[i]   = r_level[i] != w_target[i];
            w_on[i]     = (r_level[i] == MAX) | (r_pwm < r_level[i]);
        end
    end

    // Timebase: prescaler -> PWM counter -> frame counter -> blink counter and phase
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ps          <= '0;
            r_pwm         <= '0;
            r_frame       <= '0;
            r_blink       <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_ps <= w_tick ? '0 : r_ps + 1'b1;
            if (w_tick)
                r_pwm <= r_pwm + 1'b1;
            if (w_frame_end)
                r_frame <= (r_frame == FR_W'(STEP_FRAMES - 1)) ? '0 : r_frame + 1'b1;
            if (w_step)
                r_blink <= w_blink_wrap ? '0 : r_blink + 1'b1;
            r_blink_phase <= r_blink_phase ^ w_blink_wrap;
        end
    end

    // Input capture, level tracking and registered LED drive / busy flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pattern <= '0;
            led_o     <= '0;
            busy      <= 1'b0;
            for (int i = 0; i < N_LEDS; i++)
                r_level[i] <= '0;
        end else begin
            r_pattern <= led_pattern;
            led_o     <= w_on;
            busy      <= |w_diff;
            for (int i = 0; i < N_LEDS; i++)
                r_level[i] <= w_next[i];
        end
    end
endmodule

// File: doc/led_fade_driver.md
Name: led_fade_driver

Overview:
- Downstream consumer of the 14-bit LED PIO out_port. Turns the software-written on/off pattern into per-LED PWM drive for the board LEDs.
- Adds global brightness, an optional linear fade-in/fade-out per LED, and an optional global blink.
- Sits between the LED PIO output and the top-level LEDR pins, in the same clk domain as the PIO.

Parameters:
N_LEDS, 14, number of LED channels; width of led_pattern and led_o.
DUTY_W, 4, width of brightness, per-LED level and PWM counter; MAX = 2^DUTY_W-1.
PWM_DIV, 4, clk cycles per PWM tick; must be >= 1.
STEP_FRAMES, 2, PWM frames per fade step; must be >= 1.
BLINK_STEPS, 4, fade steps per blink half-period; must be >= 1.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous, active-low reset.
led_pattern  in  N_LEDS  on/off request per LED, driven from PIO out_port.
brightness  in  DUTY_W  global on-level target (0 = off, MAX = fully on).
fade_en  in  1  1 = levels ramp by 1 per fade step; 0 = levels track target directly.
blink_en  in  1  1 = gate targets with the blink phase.
led_o  out  N_LEDS  registered PWM drive to LEDs.
busy  out  1  registered; 1 while any level differs from its target.

Behaviour:
- Reset (asynchronous assert, synchronous release): all of the following clear to 0: pattern_q, prescaler, pwm_cnt, frame counter, step counter, blink counter, blink_phase, every level[i], led_o and busy. Reset mid-fade abandons the ramp, and LEDs are dark immediately.
- Input stage: pattern_q <= led_pattern every clk. This gives one cycle of input latency.
- Tick: prescaler counts 0..PWM_DIV-1 and wraps. tick = (prescaler == PWM_DIV-1).
- PWM counter: pwm_cnt increments on tick and wraps MAX->0. frame_end = tick & (pwm_cnt == MAX). Frame length = PWM_DIV*2^DUTY_W clk (64 at defaults).
- Fade step: a frame counter counts frame_end events 0..STEP_FRAMES-1. step = frame_end & (frame counter == STEP_FRAMES-1). This gives a step every 128 clk at defaults.
- Blink: blink counter counts steps 0..BLINK_STEPS-1. On its wrap, blink_phase toggles. Phase 0 = visible. The counter runs regardless of blink_en.
- Target: target[i] = (pattern_q[i] & ~(blink_en & blink_phase)) ? brightness : 0. It is evaluated combinationally each cycle, so pattern and brightness changes take effect at once.
- Level update:
  - fade_en=0: level[i] <= target[i] every clk.
  - fade_en=1: on step only, level[i] moves exactly 1 toward target[i] (+1 if below, -1 if above, hold if equal).
  - Levels never overshoot and never wrap; arithmetic is unsigned DUTY_W.
  - A target change mid-ramp reverses or redirects the ramp on the next step.
  - Switching fade_en 1->0 snaps levels to target on the next clk.
- Output: led_o[i] <= (level[i] == MAX) | (pwm_cnt < level[i]), registered.
  - level 0 gives constant 0. MAX gives constant 1. Level L is high L of each 2^DUTY_W ticks.
  - Latency from a led_pattern change with fade_en=0: pattern_q at +1, level at +2, led_o at +3 clk.
- busy <= OR over i of (level[i] != target[i]), registered. busy is 0 whenever fade_en=0 and inputs are stable.
- Simultaneous step and target change in the same cycle: the step uses the new target.

Test Plan:
1. Reset, fade_en=0, blink_en=0, brightness=15, led_pattern=0x0001 -> led_o=0x0001 constant from 3rd clk after the change; busy=0; other bits 0.
2. brightness=8, fade_en=0, pattern=0x3FFF -> every led_o bit high exactly 32 of each 64 clk, all bits in phase, aligned to pwm_cnt 0..7.
3. fade_en=1, brightness=15, pattern 0->0x2000 -> level[13] rises 1 per 128 clk; busy=1 until level reaches 15 after 15 steps (~1920 clk), then busy=0 and led_o[13] constant 1. Then set pattern=0 -> symmetric ramp down to constant 0.
4. Mid-ramp reversal: fade_en=1, ramp up to level 6, then clear pattern -> next step gives level 5, no overshoot, no jump to 0.
5. blink_en=1, fade_en=0, brightness=15, pattern=0x0003 -> led_o[1:0] alternate 512 clk on / 512 clk off; blink_en=0 -> constant on within 3 clk.
6. Assert reset_n=0 mid-fade (level 9) -> led_o=0 and busy=0 asynchronously. After release with the same inputs and fade_en=1 -> ramp restarts from 0.
